// File: rtl/edge_arb_pkg.sv
// ----------------------------------------------------------------------------
// edge_arb_pkg
// Shared types for the edge event arbiter.
//   arb_state_t : presentation FSM states (ARB_IDLE, ARB_PRESENT)
//   edge_slot_t : one channel's pending slot (pend, rise, and ts when
//                 EDGE_ARB_TS_EN is defined)
// Macro: EDGE_ARB_TS_EN adds a timestamp field to the slot. The field is
// EDGE_ARB_TS_W_MAX bits wide. The top level zero-extends its TS_W-bit
// counter into it and truncates it back on presentation, so TS_W can stay a
// parameter of the top.
// ----------------------------------------------------------------------------
package edge_arb_pkg;

    localparam int unsigned EDGE_ARB_TS_W_MAX = 32;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

`ifdef EDGE_ARB_TS_EN
    typedef struct packed {
        logic                         pend;
        logic                         rise;
        logic [EDGE_ARB_TS_W_MAX-1:0] ts;
    } edge_slot_t;
`else
    typedef struct packed {
        logic pend;
        logic rise;
    } edge_slot_t;
`endif

    localparam edge_slot_t EDGE_SLOT_EMPTY = '0;

endpackage

// File: rtl/edge_arb_chan.sv
// ----------------------------------------------------------------------------
// edge_arb_chan
// One input channel: edge detection, edge qualification, pending slot and
// sticky overflow flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sig_in     synchronized input line
//   rise_en    capture rising edges
//   fall_en    capture falling edges
//   grant      arbiter takes this slot this cycle (clears pend)
//   ovf_clr    one-cycle pulse clearing ovf
//   ts_now     current timestamp, zero-extended (EDGE_ARB_TS_EN only)
//   slot       registered pending slot
//   ovf        registered sticky overflow flag
// Macro: EDGE_ARB_TS_EN enables the timestamp capture.
// ----------------------------------------------------------------------------
module edge_arb_chan
    import edge_arb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sig_in,
    input  logic                         rise_en,
    input  logic                         fall_en,
    input  logic                         grant,
    input  logic                         ovf_clr,
`ifdef EDGE_ARB_TS_EN
    input  logic [EDGE_ARB_TS_W_MAX-1:0] ts_now,
`endif
    output edge_slot_t                   slot,
    output logic                         ovf
);

    logic       sig_d1_r;
    edge_slot_t slot_r;
    logic       ovf_r;

    logic rise_s;
    logic fall_s;
    logic qual_s;
    logic load_s;
    logic drop_s;

    // Edge detection, qualification, and the load/drop decision.
    // A slot that is being granted this cycle counts as free, so a
    // simultaneous edge refills it instead of overflowing.
    always_comb begin
        rise_s = sig_in & ~sig_d1_r;
        fall_s = ~sig_in & sig_d1_r;
        qual_s = (rise_s & rise_en) | (fall_s & fall_en);
        load_s = qual_s & (~slot_r.pend | grant);
        drop_s = qual_s & slot_r.pend & ~grant;
    end

    // Input history, pending slot and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d1_r <= 1'b0;
            slot_r   <= EDGE_SLOT_EMPTY;
            ovf_r    <= 1'b0;
        end else begin
            sig_d1_r <= sig_in;
            if (load_s) begin
                slot_r.pend <= 1'b1;
                slot_r.rise <= rise_s;
`ifdef EDGE_ARB_TS_EN
                slot_r.ts   <= ts_now;
`endif
            end else if (grant) begin
                slot_r.pend <= 1'b0;
            end else begin
                slot_r <= slot_r;
            end
            // A new overflow beats a clear in the same cycle.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign slot = slot_r;
    assign ovf  = ovf_r;

endmodule

// File: rtl/edge_event_arbiter.sv
// ----------------------------------------------------------------------------
// edge_event_arbiter
// Captures enabled rise/fall edges on NCH channels as pending events and
// serializes them round-robin onto one valid/ready event port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   sig_in      synchronized input lines [NCH]
//   rise_en     per-channel rising-edge capture enable [NCH]
//   fall_en     per-channel falling-edge capture enable [NCH]
//   evt_valid   event presented
//   evt_ready   consumer accepts event
//   evt_ch      channel of presented event
//   evt_rise    1 = rising edge, 0 = falling edge
//   ovf         sticky per-channel overflow (event dropped) [NCH]
//   ovf_clr     per-channel overflow clear pulse [NCH]
//   evt_ts      timestamp of presented event (EDGE_ARB_TS_EN only)
// Macro: EDGE_ARB_TS_EN adds a free-running TS_W-bit counter, per-slot
// timestamps and the evt_ts port.
// ----------------------------------------------------------------------------
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned TS_W = 16
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          sig_in,
    input  logic [NCH-1:0]          rise_en,
    input  logic [NCH-1:0]          fall_en,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(NCH)-1:0]  evt_ch,
    output logic                    evt_rise,
    output logic [NCH-1:0]          ovf,
    input  logic [NCH-1:0]          ovf_clr
`ifdef EDGE_ARB_TS_EN
    ,
    output logic [TS_W-1:0]         evt_ts
`endif
);

    localparam int unsigned CH_W = $clog2(NCH);

    if (NCH < 2 || NCH > 32 || TS_W < 1 || TS_W > EDGE_ARB_TS_W_MAX) begin : g_param_check
        $error("edge_event_arbiter: NCH must be 2..32 and TS_W 1..32");
    end

    edge_slot_t       slot_s [NCH];
    logic [NCH-1:0]   pend_s;
    logic [NCH-1:0]   grant_s;
    logic [NCH-1:0]   ovf_s;

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    logic             load_s;
    logic             found_s;
    logic [CH_W-1:0]  gnt_idx_s;
    logic [CH_W-1:0]  rr_ptr_r;

    logic             evt_valid_r;
    logic [CH_W-1:0]  evt_ch_r;
    logic             evt_rise_r;

`ifdef EDGE_ARB_TS_EN
    logic [TS_W-1:0]              ts_cnt_r;
    logic [TS_W-1:0]              evt_ts_r;
    logic [EDGE_ARB_TS_W_MAX-1:0] ts_ext_s;

    // Free-running timestamp; wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_r <= {TS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    assign ts_ext_s = EDGE_ARB_TS_W_MAX'(ts_cnt_r);
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        edge_arb_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .sig_in  (sig_in[g]),
            .rise_en (rise_en[g]),
            .fall_en (fall_en[g]),
            .grant   (grant_s[g]),
            .ovf_clr (ovf_clr[g]),
`ifdef EDGE_ARB_TS_EN
            .ts_now  (ts_ext_s),
`endif
            .slot    (slot_s[g]),
            .ovf     (ovf_s[g])
        );
        assign pend_s[g] = slot_s[g].pend;
    end

    // Round-robin search: first pending channel after rr_ptr, wrapping.
    always_comb begin : p_rr_search
        int unsigned     cand_v;
        logic [CH_W-1:0] idx_v;
        found_s   = 1'b0;
        gnt_idx_s = {CH_W{1'b0}};
        cand_v    = 32'd0;
        idx_v     = {CH_W{1'b0}};
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand_v = 32'(rr_ptr_r) + i;
            if (cand_v >= NCH) begin
                cand_v = cand_v - NCH;
            end else begin
                cand_v = cand_v;
            end
            idx_v = CH_W'(cand_v);
            if (!found_s && pend_s[idx_v]) begin
                found_s   = 1'b1;
                gnt_idx_s = idx_v;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Presentation FSM next-state; a grant happens only from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ARB_PRESENT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_PRESENT: begin
                if (evt_ready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_PRESENT;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // One-hot grant to the channel whose slot is being taken.
    always_comb begin
        grant_s = {NCH{1'b0}};
        if (load_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = {NCH{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output registers and round-robin pointer; loaded only on a grant so
    // the presented event stays stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= {CH_W{1'b0}};
            evt_rise_r  <= 1'b0;
            rr_ptr_r    <= CH_W'(NCH - 1);
`ifdef EDGE_ARB_TS_EN
            evt_ts_r    <= {TS_W{1'b0}};
`endif
        end else begin
            evt_valid_r <= (state_nxt_s == ARB_PRESENT);
            if (load_s) begin
                evt_ch_r   <= gnt_idx_s;
                evt_rise_r <= slot_s[gnt_idx_s].rise;
                rr_ptr_r   <= gnt_idx_s;
`ifdef EDGE_ARB_TS_EN
                evt_ts_r   <= slot_s[gnt_idx_s].ts[TS_W-1:0];
`endif
            end else begin
                rr_ptr_r   <= rr_ptr_r;
            end
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;
    assign evt_rise  = evt_rise_r;
    assign ovf       = ovf_s;
`ifdef EDGE_ARB_TS_EN
    assign evt_ts    = evt_ts_r;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ----------------------------------------------------------------------------
// tb_edge_event_arbiter
// Directed stimulus for edge_event_arbiter with a cycle-level behavioural
// model compared against the DUT on every falling edge, plus literal
// expectations at known cycles. Define EDGE_ARB_TS_EN to also exercise
// timestamps (TS_W = 4 in that build).
// ----------------------------------------------------------------------------
module tb_edge_event_arbiter;

    localparam int NCH = 4;
`ifdef EDGE_ARB_TS_EN
    localparam int TS_W = 4;
`else
    localparam int TS_W = 16;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] sig_in;
    logic [NCH-1:0] rise_en;
    logic [NCH-1:0] fall_en;
    logic           evt_valid;
    logic           evt_ready;
    logic [1:0]     evt_ch;
    logic           evt_rise;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] ovf_clr;
`ifdef EDGE_ARB_TS_EN
    logic [TS_W-1:0] evt_ts;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: what the outputs must be after the latest clock edge.
    logic [NCH-1:0] m_prev;
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_prise;
    logic [NCH-1:0] m_ovf;
    int             m_pts [NCH];
    bit             m_valid;
    int             m_ch;
    bit             m_rise;
    int             m_ts;
    int             m_last;
    int             m_cnt;

    edge_event_arbiter #(.NCH(NCH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef EDGE_ARB_TS_EN
        ,
        .evt_ts    (evt_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_prise = '0;
        m_ovf   = '0;
        for (int c = 0; c < NCH; c++) m_pts[c] = 0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_rise  = 1'b0;
        m_ts    = 0;
        m_last  = NCH - 1;
        m_cnt   = 0;
    endtask

    // One clock edge of the model, from the inputs seen at that edge.
    task automatic model_step();
        int  g;
        bit  r;
        bit  f;
        bit  q;
        if (rst) begin
            model_reset();
        end else begin
            g = -1;
            if (!m_valid) begin
                for (int i = 1; i <= NCH; i++) begin
                    if (g < 0 && m_pend[(m_last + i) % NCH]) g = (m_last + i) % NCH;
                end
            end
            if (m_valid) begin
                if (evt_ready) m_valid = 1'b0;
            end else if (g >= 0) begin
                m_valid   = 1'b1;
                m_ch      = g;
                m_rise    = m_prise[g];
                m_ts      = m_pts[g];
                m_last    = g;
                m_pend[g] = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                r = sig_in[c] & ~m_prev[c];
                f = ~sig_in[c] & m_prev[c];
                q = (r & rise_en[c]) | (f & fall_en[c]);
                if (ovf_clr[c]) m_ovf[c] = 1'b0;
                if (q) begin
                    if (m_pend[c]) begin
                        m_ovf[c] = 1'b1;
                    end else begin
                        m_pend[c]  = 1'b1;
                        m_prise[c] = r;
                        m_pts[c]   = m_cnt;
                    end
                end
            end
            m_prev = sig_in;
            m_cnt  = (m_cnt + 1) % (1 << TS_W);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_valid", {31'd0, evt_valid}, {31'd0, m_valid});
                chk("m_ch", {30'd0, evt_ch}, m_ch);
                chk("m_rise", {31'd0, evt_rise}, {31'd0, m_rise});
                chk("m_ovf", {28'd0, ovf}, {28'd0, m_ovf});
`ifdef EDGE_ARB_TS_EN
                chk("m_ts", {28'd0, evt_ts}, m_ts);
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sig_in = '0;
        rst    = 1'b1;
        step(2);
        rst    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig_in = '0; rise_en = '0; fall_en = '0;
        evt_ready = 1'b0; ovf_clr = '0;
        step(2);
        cmp_en = 1'b1;
        rst = 1'b0;
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        chk("rst_ch", {30'd0, evt_ch}, 32'd0);

        // Single rise on ch2: two-cycle latency.
        rise_en = 4'b1111; evt_ready = 1'b1;
        sig_in[2] = 1'b1;
        step(1);
        chk("t1_not_yet", {31'd0, evt_valid}, 32'd0);
        step(1);
        chk("t1_valid", {31'd0, evt_valid}, 32'd1);
        chk("t1_ch", {30'd0, evt_ch}, 32'd2);
        chk("t1_rise", {31'd0, evt_rise}, 32'd1);
        step(2);
        sig_in[2] = 1'b0;
        step(2);

        // All four channels at once after reset: order 0,1,2,3 with gaps.
        do_reset();
        sig_in = 4'b1111;
        step(2);
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", {31'd0, evt_valid}, 32'd1);
            chk("t2_ch", {30'd0, evt_ch}, k);
            step(1);
            chk("t2_gap", {31'd0, evt_valid}, 32'd0);
            step(1);
        end
        chk("t2_ovf", {28'd0, ovf}, 32'd0);

        // ch1 rise/fall/rise with consumer stalled: one overflow.
        fall_en = 4'b0000; sig_in = 4'b0000;
        step(2);
        evt_ready = 1'b0; fall_en = 4'b1111;
        sig_in[1] = 1'b1; step(1);
        sig_in[1] = 1'b0; step(1);
        sig_in[1] = 1'b1; step(1);
        chk("t3_valid", {31'd0, evt_valid}, 32'd1);
        chk("t3_ch", {30'd0, evt_ch}, 32'd1);
        chk("t3_rise", {31'd0, evt_rise}, 32'd1);
        chk("t3_ovf", {28'd0, ovf}, 32'd2);
        evt_ready = 1'b1; ovf_clr = 4'b0010;
        step(1);
        ovf_clr = 4'b0000;
        chk("t3_ovf_clr", {28'd0, ovf}, 32'd0);
        chk("t3_gap", {31'd0, evt_valid}, 32'd0);
        step(1);
        chk("t3_fall_valid", {31'd0, evt_valid}, 32'd1);
        chk("t3_fall_rise", {31'd0, evt_rise}, 32'd0);
        step(3);

        // Disabled edge types are dropped silently.
        rise_en = 4'b0000; sig_in[3] = 1'b1; step(2);
        fall_en = 4'b0000; rise_en = 4'b1111; sig_in[3] = 1'b0; step(4);
        chk("t4_quiet", {31'd0, evt_valid}, 32'd0);
        chk("t4_ovf", {28'd0, ovf}, 32'd0);
        fall_en = 4'b1000;
        sig_in[3] = 1'b1; step(2);
        chk("t4_rise_ch", {30'd0, evt_ch}, 32'd3);
        chk("t4_rise", {31'd0, evt_rise}, 32'd1);
        sig_in[3] = 1'b0; step(2);
        chk("t4_fall_valid", {31'd0, evt_valid}, 32'd1);
        chk("t4_fall", {31'd0, evt_rise}, 32'd0);
        step(2);

        // New overflow beats a same-cycle clear.
        evt_ready = 1'b0; fall_en = 4'b1111;
        sig_in[0] = 1'b1; step(1);
        sig_in[0] = 1'b0; step(1);
        sig_in[0] = 1'b1; ovf_clr = 4'b0001; step(1);
        ovf_clr = 4'b0000;
        chk("t5_ovf_sticky", {28'd0, ovf}, 32'd1);

        // Reset while presenting with other channels pending.
        sig_in[2] = 1'b1; sig_in[3] = 1'b1; step(1);
        chk("t6_pre_valid", {31'd0, evt_valid}, 32'd1);
        rst = 1'b1; sig_in = 4'b0000; step(1);
        chk("t6_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("t6_rst_ovf", {28'd0, ovf}, 32'd0);
        rst = 1'b0; evt_ready = 1'b1; step(6);
        chk("t6_no_events", {31'd0, evt_valid}, 32'd0);
        sig_in[1] = 1'b1; step(2);
        chk("t6_new_ch", {30'd0, evt_ch}, 32'd1);
        step(2);

`ifdef EDGE_ARB_TS_EN
        // Timestamps at counter values 3 and 15, then 2 after wrap.
        do_reset();
        evt_ready = 1'b0; rise_en = 4'b0001; fall_en = 4'b0001;
        step(3);
        sig_in[0] = 1'b1; step(12);
        sig_in[0] = 1'b0; step(1);
        evt_ready = 1'b1;
        chk("t7_ts3", {28'd0, evt_ts}, 32'd3);
        step(2);
        chk("t7_ts15", {28'd0, evt_ts}, 32'd15);
        chk("t7_ts15_fall", {31'd0, evt_rise}, 32'd0);
        sig_in[0] = 1'b1; step(2);
        chk("t7_ts_wrap", {28'd0, evt_ts}, 32'd2);
        step(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge event controller. Detects rise/fall edges on NCH synchronous input signals and latches each enabled edge as a pending event per channel. It then serializes pending events through a round-robin arbiter onto a single valid/ready event port. Sits between synchronized status/interrupt lines and a single event consumer (CPU interrupt queue, logging FIFO).

## Interface
- NCH, 4: number of input channels (2..32)
- TS_W, 16: timestamp width (used only with EDGE_ARB_TS_EN)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sig_in  in  NCH  already-synchronized input signals
- rise_en  in  NCH  per-channel rise-edge capture enable
- fall_en  in  NCH  per-channel fall-edge capture enable
- evt_valid  out  1  event presented
- evt_ready  in  1  consumer accepts event
- evt_ch  out  $clog2(NCH)  channel index of presented event
- evt_rise  out  1  1 = rising edge, 0 = falling edge
- ovf  out  NCH  sticky per-channel overflow (event dropped)
- ovf_clr  in  NCH  per-channel overflow clear, one-cycle pulse
- evt_ts  out  TS_W  timestamp of presented event (EDGE_ARB_TS_EN only)

## Operation
- Per channel: sig_d1 register (reset 0); rise = sig_in & ~sig_d1, fall = ~sig_in & sig_d1. A channel that is high out of reset therefore produces a rise.
- Qualified edge = (rise & rise_en) | (fall & fall_en). Disabled edge types are discarded silently; no ovf.
- Pending slot per channel: pend bit + pend_rise bit (+ timestamp). A qualified edge with pend=0 loads the slot.
- Qualified edge with pend=1, and the slot is not being granted this cycle: event dropped, slot unchanged, ovf[ch] set.
- Qualified edge on the channel being granted in the same cycle: the new event loads the slot (set wins over clear). No ovf.
- ovf_clr[ch] and a new overflow on ch in the same cycle: ovf stays 1.
- FSM, two states:
  - IDLE: evt_valid=0. If any pend, grant the first pending channel searching from rr_ptr+1 with wrap-around. Load evt_ch/evt_rise/evt_ts from its slot, clear that pend, set rr_ptr to the granted channel, go to PRESENT.
  - PRESENT: evt_valid=1, outputs held stable. On evt_ready go to IDLE.
- rr_ptr resets to NCH-1, so channel 0 has first priority after reset.
- Reset values: evt_valid=0, evt_ch=0, evt_rise=0, evt_ts=0, ovf=0, all pend=0, FSM=IDLE.
- Reset mid-operation drops the presented event and all pending events.

## Timing
- Edge in cycle t (sig_in differs from sig_d1) → pend set at end of t → grant at end of t+1 → evt_valid=1 in cycle t+2 (2-cycle latency when idle).
- Handshake completes on a cycle with evt_valid & evt_ready. The next grant occurs in the following cycle, so evt_valid is low for exactly one cycle. Maximum throughput is 1 event per 2 cycles.
- evt_valid is never withdrawn without evt_ready. evt_ch, evt_rise and evt_ts are stable while evt_valid=1.
- ovf sets one cycle after the dropped edge and clears one cycle after ovf_clr.

## Configuration
- EDGE_ARB_TS_EN defined: a free-running TS_W counter runs (reset 0, wraps at 2^TS_W-1 → 0). A slot captures the counter value in the cycle its edge is detected, and evt_ts presents that value.
- Without the macro: no counter, no per-slot timestamp storage, no evt_ts port.

## Structure
- Shared package edge_arb_pkg: FSM state enum (ARB_IDLE, ARB_PRESENT) and the slot struct (pend, rise, ts).
- Sub-module edge_arb_chan: one channel's sig_d1 register, edge qualification, pending slot and ovf bit, instantiated NCH times.
- The top level holds the round-robin search, FSM, output registers and timestamp counter.

## Test plan
- Reset, then raise sig_in[2] with rise_en=all ones and evt_ready=1 → evt_valid=1 two cycles later, evt_ch=2, evt_rise=1. The first grant after reset goes to ch0 if ch0 is also pending.
- Raise sig_in[0..3] in the same cycle with evt_ready=1 → grants in order 0,1,2,3, each followed by one idle cycle, no ovf.
- Hold evt_ready=0 and toggle ch1 three times (rise, fall, rise) → one event presented, one pending, ovf[1]=1. Pulse ovf_clr[1] → ovf[1]=0 on the next cycle.
- Set fall_en=0 and drop sig_in[3] → no event and no ovf. Set fall_en[3]=1 and raise then drop sig_in[3] → rise event, then fall event with evt_rise=0.
- Assert rst while evt_valid=1 with two channels pending → next cycle evt_valid=0, ovf=0, and no events after reset deasserts until a new edge.
- With EDGE_ARB_TS_EN and TS_W=4: edges on ch0 at counter values 3 and 15, with evt_ready held low in between → evt_ts=3, then 15. Counter wraps to 0.
